// File: rtl/raymarch_scheduler.sv
// raymarch_scheduler
//
// Walks a WIDTH x HEIGHT frame in raster order, presenting one pixel
// coordinate at a time to the raymarcher core. It waits for the raymarcher's
// result with matching coordinates, or substitutes BG_COLOR after TIMEOUT
// cycles. It then writes the packed {R,G,B} value to the framebuffer.
//
// Handshake: the framebuffer write is a valid/ready pair. fb_we is valid and
// fb_ready is ready. A write is accepted on a rising edge where both are high.
// fb_we stays high, and fb_addr and fb_data stay frozen, until that happens.
//
// Ports
//   clk_pixel_in    : single clock, rising edge
//   rst_in          : asynchronous active-high reset
//   start_in        : begin a frame (only looked at in IDLE)
//   curr_x, curr_y  : coordinate presented to the raymarcher
//   pixel_done      : raymarcher result strobe
//   out_x, out_y    : coordinate of the completed result
//   red_in, green_in, blue_in : result colour
//   fb_addr, fb_data, fb_we, fb_ready : framebuffer write port
//   busy            : frame in progress
//   frame_done      : one-cycle pulse after the last write is accepted
//   mismatch_count  : saturating count of results with the wrong coordinate
//   timeout_count   : saturating count of pixels replaced by BG_COLOR
//   state_dbg       : current FSM state, for observation only
module raymarch_scheduler #(
    parameter int          WIDTH      = 300,
    parameter int          HEIGHT     = 300,
    parameter int          TIMEOUT    = 4096,
    parameter logic [23:0] BG_COLOR   = 24'h000000,
    parameter bit          CONTINUOUS = 1'b0,
    localparam int         AW         = $clog2(WIDTH*HEIGHT)
) (
    input  logic          clk_pixel_in,
    input  logic          rst_in,
    input  logic          start_in,
    output logic [32:0]   curr_x,
    output logic [32:0]   curr_y,
    input  logic          pixel_done,
    input  logic [32:0]   out_x,
    input  logic [32:0]   out_y,
    input  logic [7:0]    red_in,
    input  logic [7:0]    green_in,
    input  logic [7:0]    blue_in,
    output logic [AW-1:0] fb_addr,
    output logic [23:0]   fb_data,
    output logic          fb_we,
    input  logic          fb_ready,
    output logic          busy,
    output logic          frame_done,
    output logic [15:0]   mismatch_count,
    output logic [15:0]   timeout_count,
    output logic [1:0]    state_dbg
);

    localparam int          TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer;

    logic match;
    logic timed_out;
    logic accept;
    logic last_pixel;

    assign match      = pixel_done && (out_x == curr_x) && (out_y == curr_y);
    assign timed_out  = (timer == TLAST);
    assign accept     = (state == WRITE) && fb_ready;
    assign last_pixel = (curr_x == 33'(WIDTH - 1)) && (curr_y == 33'(HEIGHT - 1));

    // State register
    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and decoded outputs
    always_comb begin
        state_next = state;
        fb_we      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // A matching result beats a timeout in the same cycle.
                if (match || (!pixel_done && timed_out)) state_next = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                fb_we = 1'b1;
                if (fb_ready) state_next = last_pixel ? DONE : WAIT;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_next = CONTINUOUS ? WAIT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign state_dbg = state;

    // Coordinate, address, data, timer and counter registers
    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            curr_x         <= '0;
            curr_y         <= '0;
            fb_addr        <= '0;
            fb_data        <= '0;
            timer          <= '0;
            mismatch_count <= '0;
            timeout_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        curr_x  <= '0;
                        curr_y  <= '0;
                        fb_addr <= '0;
                        timer   <= '0;
                    end
                end
                WAIT: begin
                    // The timer holds at its last value. A wrong-coordinate
                    // result landing on the timeout cycle therefore defers
                    // the timeout by one cycle instead of wrapping the timer.
                    if (!timed_out) timer <= timer + TW'(1);
                    if (match) begin
                        fb_data <= {red_in, green_in, blue_in};
                    end else if (pixel_done) begin
                        if (mismatch_count != 16'hFFFF)
                            mismatch_count <= mismatch_count + 16'd1;
                    end else if (timed_out) begin
                        fb_data <= BG_COLOR;
                        if (timeout_count != 16'hFFFF)
                            timeout_count <= timeout_count + 16'd1;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (curr_x == 33'(WIDTH - 1)) begin
                            curr_x <= '0;
                            curr_y <= curr_y + 33'd1;
                        end else begin
                            curr_x <= curr_x + 33'd1;
                        end
                        // Raster order makes the address a plain counter.
                        fb_addr <= fb_addr + AW'(1);
                        timer   <= '0;
                    end
                end
                DONE: begin
                    if (CONTINUOUS) begin
                        curr_x  <= '0;
                        curr_y  <= '0;
                        fb_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
